// File: rtl/rx_readout_sched.sv
// Round-robin readout of NCH receiver channels: each grant sequences I, Q and packed-MSB
// reads into the sample FIFO, with a mandatory IDLE cycle between groups.
module rx_readout_sched #(
    parameter int NCH         = 8,
    parameter int CH_BITS     = 3,
    parameter int BLOCK_SAMPS = 170
) (
    input  logic               adc_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NCH-1:0]     rx_avail,
    input  logic [15:0]        rx_dout,
    output logic [CH_BITS-1:0] rx_chan,
    output logic               rd_getI,
    output logic               rd_getQ,
    output logic               wr_en,
    output logic [15:0]        wr_data,
    input  logic               fifo_afull,
    output logic [NCH-1:0]     overrun,
    input  logic               clr_overrun,
    output logic               block_done,
    output logic [15:0]        samp_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GET_I = 2'd1,
        S_GET_Q = 2'd2,
        S_GET_X = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NCH-1:0]     r_pending;
    logic [NCH-1:0]     w_pending_nxt;
    logic [NCH-1:0]     r_overrun;
    logic [NCH-1:0]     w_ovr_set;
    logic [NCH-1:0]     w_busy_oh;
    logic [CH_BITS-1:0] r_chan;
    logic [CH_BITS-1:0] r_last;
    logic [CH_BITS-1:0] w_grant;
    logic [CH_BITS-1:0] w_idx;
    logic               w_grant_found;
    logic               w_do_grant;
    logic               w_blk_wrap;
    logic [15:0]        r_samp_cnt;
    logic [15:0]        w_samp_inc;
    logic               r_block_done;

    // Search starts just after the last grant so every channel gets a fair turn.
    always_comb begin
        w_grant       = r_last;
        w_grant_found = 1'b0;
        w_idx         = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = CH_BITS'((int'(r_last) + k) % NCH);
            if (!w_grant_found && r_pending[w_idx]) begin
                w_grant       = w_idx;
                w_grant_found = 1'b1;
            end
        end
    end

    assign w_do_grant = (r_state == S_IDLE) && enable && (|r_pending) && !fifo_afull;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_do_grant) w_state_nxt = S_GET_I;
            S_GET_I: w_state_nxt = S_GET_Q;
            S_GET_Q: w_state_nxt = S_GET_X;
            S_GET_X: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A channel re-requesting while still queued or being read out has lost a sample.
    assign w_busy_oh = (r_state != S_IDLE) ? (NCH'(1) << r_chan) : '0;
    assign w_ovr_set = enable ? (rx_avail & (r_pending | w_busy_oh)) : '0;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_do_grant) begin
            w_pending_nxt = r_pending & ~(NCH'(1) << w_grant);
        end
        if (enable) begin
            w_pending_nxt = w_pending_nxt | rx_avail;
        end else if (w_state_nxt == S_IDLE) begin
            w_pending_nxt = '0;
        end
    end

    assign w_samp_inc = r_samp_cnt + 16'd1;
    assign w_blk_wrap = (r_state == S_GET_X) && (w_samp_inc == 16'(BLOCK_SAMPS));

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_overrun    <= '0;
            r_chan       <= '0;
            r_last       <= CH_BITS'(NCH - 1);
            r_samp_cnt   <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_overrun    <= (clr_overrun ? '0 : r_overrun) | w_ovr_set;
            r_block_done <= w_blk_wrap;
            if (w_do_grant) begin
                r_chan <= w_grant;
                r_last <= w_grant;
            end
            if (r_state == S_GET_X) begin
                r_samp_cnt <= w_blk_wrap ? 16'd0 : w_samp_inc;
            end
        end
    end

    assign rx_chan    = r_chan;
    assign rd_getI    = (r_state == S_GET_I);
    assign rd_getQ    = (r_state == S_GET_Q);
    assign wr_en      = (r_state != S_IDLE);
    assign wr_data    = wr_en ? rx_dout : 16'd0;
    assign overrun    = r_overrun;
    assign block_done = r_block_done;
    assign samp_count = r_samp_cnt;

endmodule
